// File: rtl/cpu_operand_pkg.sv
// Shared constants and helpers for the operand unit and its forwarding muxes.
package cpu_operand_pkg;

    // Default instruction tag width.
    localparam int TAG_W_DEFAULT = 4;

    // The hardwired-zero architectural register.
    localparam int REG_ZERO = 0;

    // Register index width for a power-of-two register count.
    function automatic int idx_width(input int nregs);
        return $clog2(nregs);
    endfunction

endpackage

// File: rtl/cpu_forward_mux.sv
// Per-read-port operand select: zero register, youngest matching forward source,
// else the captured register-file data. Also flags a dependency on a pending source.
module cpu_forward_mux
    import cpu_operand_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int IDX_W = 5,
    parameter int NFWD  = 3
) (
    input  logic [IDX_W-1:0]      i_cap_idx,
    input  logic [XLEN-1:0]       i_cap_data,
    input  logic [NFWD-1:0]       i_fwd_valid,
    input  logic [NFWD-1:0]       i_fwd_pending,
    input  logic [NFWD*IDX_W-1:0] i_fwd_idx,
    input  logic [NFWD*XLEN-1:0]  i_fwd_data,
    output logic [XLEN-1:0]       o_operand,
    output logic                  o_hazard
);

    // Scan oldest to youngest so the lowest matching source is applied last and wins.
    always_comb begin
        o_operand = i_cap_data;
        o_hazard  = 1'b0;
        for (int s = NFWD - 1; s >= 0; s--) begin
            if (i_fwd_valid[s] && (i_fwd_idx[s*IDX_W +: IDX_W] == i_cap_idx)) begin
                o_operand = i_fwd_data[s*XLEN +: XLEN];
                o_hazard  = i_fwd_pending[s];
            end
        end
        if (i_cap_idx == IDX_W'(REG_ZERO)) begin
            o_operand = '0;
            o_hazard  = 1'b0;
        end
    end

endmodule

// File: rtl/cpu_operand_unit.sv
// Operand unit: register file with tag-change write acceptance, stall-aware read
// capture with write-through, priority forwarding and load-use hazard output.
module cpu_operand_unit
    import cpu_operand_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int NREGS = 32,
    parameter int NREAD = 2,
    parameter int NFWD  = 3,
    parameter int TAG_W = TAG_W_DEFAULT
) (
    input  logic                                 i_clock,
    input  logic                                 i_reset,
    input  logic                                 i_stall,
    input  logic [NREAD*idx_width(NREGS)-1:0]    i_read_idx,
    input  logic [NFWD-1:0]                      i_fwd_valid,
    input  logic [NFWD-1:0]                      i_fwd_pending,
    input  logic [NFWD*idx_width(NREGS)-1:0]     i_fwd_idx,
    input  logic [NFWD*XLEN-1:0]                 i_fwd_data,
    input  logic [TAG_W-1:0]                     i_write_tag,
    input  logic [idx_width(NREGS)-1:0]          i_write_idx,
    input  logic [XLEN-1:0]                      i_write_data,
    output logic [NREAD*XLEN-1:0]                o_operand,
    output logic                                 o_hazard,
    output logic [31:0]                          o_retire_count
);

    localparam int IDX_W = idx_width(NREGS);

    logic [XLEN-1:0]                 regs [NREGS];
    logic [TAG_W-1:0]                last_tag;
    logic [NREAD-1:0][IDX_W-1:0]     cap_idx;
    logic [NREAD-1:0][XLEN-1:0]      cap_data;
    logic [NREAD-1:0]                port_hazard;
    logic                            wr_acc;
    logic                            wr_en;

    // A new tag marks a retiring instruction; register 0 is never written.
    assign wr_acc = (i_write_tag != last_tag);
    assign wr_en  = wr_acc && (i_write_idx != IDX_W'(REG_ZERO));

    // Register file, last accepted tag and retire counter.
    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            last_tag       <= '0;
            o_retire_count <= '0;
            for (int r = 0; r < NREGS; r++) regs[r] <= '0;
        end else if (wr_acc) begin
            last_tag       <= i_write_tag;
            o_retire_count <= o_retire_count + 32'd1;
            if (wr_en) regs[i_write_idx] <= i_write_data;
        end
    end

    // Read capture; a same-cycle write to the captured index is forwarded in,
    // including while stalled so held operands never go stale.
    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            cap_idx  <= '0;
            cap_data <= '0;
        end else begin
            for (int p = 0; p < NREAD; p++) begin
                if (!i_stall) begin
                    cap_idx[p] <= i_read_idx[p*IDX_W +: IDX_W];
                    if (wr_en && (i_write_idx == i_read_idx[p*IDX_W +: IDX_W]))
                        cap_data[p] <= i_write_data;
                    else
                        cap_data[p] <= regs[i_read_idx[p*IDX_W +: IDX_W]];
                end else if (wr_en && (i_write_idx == cap_idx[p])) begin
                    cap_data[p] <= i_write_data;
                end
            end
        end
    end

    genvar p;
    generate
        for (p = 0; p < NREAD; p++) begin : g_port
            cpu_forward_mux #(
                .XLEN  (XLEN),
                .IDX_W (IDX_W),
                .NFWD  (NFWD)
            ) u_fwd_mux (
                .i_cap_idx     (cap_idx[p]),
                .i_cap_data    (cap_data[p]),
                .i_fwd_valid   (i_fwd_valid),
                .i_fwd_pending (i_fwd_pending),
                .i_fwd_idx     (i_fwd_idx),
                .i_fwd_data    (i_fwd_data),
                .o_operand     (o_operand[p*XLEN +: XLEN]),
                .o_hazard      (port_hazard[p])
            );
        end
    endgenerate

    assign o_hazard = |port_hazard;

endmodule

// File: tb/tb_cpu_operand_unit.sv
// Self-checking bench: directed scenarios plus randomized traffic against a
// behavioural model of the register file, capture and forwarding rules.
module tb_cpu_operand_unit;

    localparam int XLEN = 32, NREGS = 32, NREAD = 2, NFWD = 3, TAG_W = 4, IDX_W = 5;

    logic                   i_clock = 1'b0;
    logic                   i_reset;
    logic                   i_stall;
    logic [NREAD*IDX_W-1:0] i_read_idx;
    logic [NFWD-1:0]        i_fwd_valid;
    logic [NFWD-1:0]        i_fwd_pending;
    logic [NFWD*IDX_W-1:0]  i_fwd_idx;
    logic [NFWD*XLEN-1:0]   i_fwd_data;
    logic [TAG_W-1:0]       i_write_tag;
    logic [IDX_W-1:0]       i_write_idx;
    logic [XLEN-1:0]        i_write_data;
    logic [NREAD*XLEN-1:0]  o_operand;
    logic                   o_hazard;
    logic [31:0]            o_retire_count;

    // Unpacked stimulus views, packed onto the DUT buses.
    logic [IDX_W-1:0] rd [NREAD];
    logic [IDX_W-1:0] fi [NFWD];
    logic [XLEN-1:0]  fd [NFWD];

    assign i_read_idx = {rd[1], rd[0]};
    assign i_fwd_idx  = {fi[2], fi[1], fi[0]};
    assign i_fwd_data = {fd[2], fd[1], fd[0]};

    cpu_operand_unit #(
        .XLEN(XLEN), .NREGS(NREGS), .NREAD(NREAD), .NFWD(NFWD), .TAG_W(TAG_W)
    ) dut (
        .i_clock        (i_clock),
        .i_reset        (i_reset),
        .i_stall        (i_stall),
        .i_read_idx     (i_read_idx),
        .i_fwd_valid    (i_fwd_valid),
        .i_fwd_pending  (i_fwd_pending),
        .i_fwd_idx      (i_fwd_idx),
        .i_fwd_data     (i_fwd_data),
        .i_write_tag    (i_write_tag),
        .i_write_idx    (i_write_idx),
        .i_write_data   (i_write_data),
        .o_operand      (o_operand),
        .o_hazard       (o_hazard),
        .o_retire_count (o_retire_count)
    );

    always #5 i_clock = ~i_clock;

    int n_chk  = 0;
    int n_fail = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Behavioural model state.
    logic [31:0] m_file [NREGS];
    logic [3:0]  m_tag;
    logic [31:0] m_count;
    logic [4:0]  m_cidx [NREAD];
    logic [31:0] m_cdat [NREAD];

    // Advance the model by one rising edge using the inputs as currently driven.
    task automatic model_step();
        bit acc, wr;
        if (i_reset) begin
            for (int r = 0; r < NREGS; r++) m_file[r] = 0;
            m_tag = 0; m_count = 0;
            for (int p = 0; p < NREAD; p++) begin m_cidx[p] = 0; m_cdat[p] = 0; end
            return;
        end
        acc = (i_write_tag != m_tag);
        wr  = acc && (i_write_idx != 0);
        for (int p = 0; p < NREAD; p++) begin
            if (!i_stall) begin
                m_cidx[p] = rd[p];
                m_cdat[p] = (wr && i_write_idx == rd[p]) ? i_write_data : m_file[rd[p]];
            end else if (wr && i_write_idx == m_cidx[p]) begin
                m_cdat[p] = i_write_data;
            end
        end
        if (acc) begin
            m_tag = i_write_tag;
            m_count = m_count + 1;
            if (wr) m_file[i_write_idx] = i_write_data;
        end
    endtask

    // Expected {hazard, operand} for a port: first matching source in age order.
    function automatic logic [32:0] exp_port(input int p);
        if (m_cidx[p] == 0) return 33'd0;
        for (int s = 0; s < NFWD; s++)
            if (i_fwd_valid[s] && fi[s] == m_cidx[p]) return {i_fwd_pending[s], fd[s]};
        return {1'b0, m_cdat[p]};
    endfunction

    task automatic check_model();
        logic [32:0] e;
        logic        hz;
        hz = 1'b0;
        for (int p = 0; p < NREAD; p++) begin
            e = exp_port(p);
            hz = hz | e[32];
            check($sformatf("operand%0d", p), o_operand[p*XLEN +: XLEN], e[31:0]);
        end
        check("hazard", {31'd0, o_hazard}, {31'd0, hz});
        check("retire_count", o_retire_count, m_count);
    endtask

    task automatic cycle();
        @(posedge i_clock);
        model_step();
        #1;
        check_model();
    endtask

    task automatic clear_fwd();
        i_fwd_valid = '0; i_fwd_pending = '0;
        for (int s = 0; s < NFWD; s++) begin fi[s] = '0; fd[s] = '0; end
    endtask

    initial begin
        i_reset = 1'b1; i_stall = 1'b0;
        i_write_tag = '0; i_write_idx = '0; i_write_data = '0;
        rd[0] = '0; rd[1] = '0;
        clear_fwd();
        #1;
        cycle(); cycle();
        i_reset = 1'b0;
        cycle();
        check("reset_operand0", o_operand[31:0], 32'd0);
        check("reset_operand1", o_operand[63:32], 32'd0);
        check("reset_count", o_retire_count, 32'd0);
        check("reset_hazard", {31'd0, o_hazard}, 32'd0);

        // Plain write then read next cycle.
        i_write_tag = 4'd1; i_write_idx = 5'd5; i_write_data = 32'hDEADBEEF;
        cycle();
        rd[0] = 5'd5;
        cycle();
        check("read_after_write", o_operand[31:0], 32'hDEADBEEF);
        check("count_after_write", o_retire_count, 32'd1);

        // Write-through on same-cycle capture, then repeated tag is ignored.
        i_write_tag = 4'd2; i_write_idx = 5'd7; i_write_data = 32'h12345678; rd[1] = 5'd7;
        cycle();
        check("write_through", o_operand[63:32], 32'h12345678);
        i_write_data = 32'h55555555;
        cycle();
        check("same_tag_no_write", o_operand[63:32], 32'h12345678);
        check("same_tag_count", o_retire_count, 32'd2);

        // Forward priority: youngest matching source wins.
        rd[0] = 5'd3;
        i_fwd_valid = 3'b101; fi[0] = 5'd3; fd[0] = 32'hA; fi[2] = 5'd3; fd[2] = 32'hC;
        cycle();
        check("fwd_youngest", o_operand[31:0], 32'hA);
        i_fwd_valid = 3'b100;
        cycle();
        check("fwd_older", o_operand[31:0], 32'hC);

        // Load-use hazard, masked by a younger ready source.
        clear_fwd();
        rd[1] = 5'd4;
        i_fwd_valid[1] = 1'b1; i_fwd_pending[1] = 1'b1; fi[1] = 5'd4; fd[1] = 32'h111;
        cycle();
        check("hazard_pending", {31'd0, o_hazard}, 32'd1);
        i_fwd_valid[0] = 1'b1; fi[0] = 5'd4; fd[0] = 32'h44;
        cycle();
        check("hazard_masked", {31'd0, o_hazard}, 32'd0);
        check("hazard_masked_op", o_operand[63:32], 32'h44);

        // Register zero: never forwarded, never hazards, never written.
        clear_fwd();
        rd[0] = 5'd0;
        i_fwd_valid[2] = 1'b1; i_fwd_pending[2] = 1'b1; fi[2] = 5'd0; fd[2] = 32'hBAD;
        cycle();
        check("zero_operand", o_operand[31:0], 32'd0);
        check("zero_hazard", {31'd0, o_hazard}, 32'd0);
        i_write_tag = 4'd3; i_write_idx = 5'd0; i_write_data = 32'hFFFFFFFF;
        cycle();
        check("zero_write_count", o_retire_count, 32'd3);
        cycle();
        check("zero_write_op", o_operand[31:0], 32'd0);

        // Stall holds capture; write-through while stalled; reset overrides.
        clear_fwd();
        rd[0] = 5'd9; i_write_tag = 4'd4; i_write_idx = 5'd9; i_write_data = 32'h99;
        cycle();
        i_stall = 1'b1; rd[0] = 5'd10;
        cycle();
        check("stall_hold", o_operand[31:0], 32'h99);
        i_write_tag = 4'd5; i_write_data = 32'h900D;
        cycle();
        check("stall_write_through", o_operand[31:0], 32'h900D);
        check("stall_count", o_retire_count, 32'd5);
        i_reset = 1'b1; i_write_tag = 4'd6;
        cycle();
        check("reset_stall_op0", o_operand[31:0], 32'd0);
        check("reset_stall_op1", o_operand[63:32], 32'd0);
        check("reset_stall_count", o_retire_count, 32'd0);
        i_reset = 1'b0; i_stall = 1'b0;
        cycle();

        // Randomized traffic over a narrow index range to force collisions.
        for (int n = 0; n < 400; n++) begin
            i_reset = ($urandom_range(0, 99) < 2);
            i_stall = ($urandom_range(0, 3) == 0);
            for (int p = 0; p < NREAD; p++) rd[p] = IDX_W'($urandom_range(0, 7));
            if ($urandom_range(0, 1) == 1) i_write_tag = TAG_W'($urandom);
            i_write_idx  = IDX_W'($urandom_range(0, 7));
            i_write_data = $urandom;
            i_fwd_valid   = NFWD'($urandom);
            i_fwd_pending = NFWD'($urandom);
            for (int s = 0; s < NFWD; s++) begin
                fi[s] = IDX_W'($urandom_range(0, 7));
                fd[s] = $urandom;
            end
            cycle();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/cpu_operand_unit.md
# cpu_operand_unit

Parametrised operand unit for the Rv32H pipeline: integer register file, registered read capture, N-source priority forwarding and load-use hazard detection in one block. It sits between fetch/decode and execute, replacing the fixed two-port register file and hand-written forwarding muxes. It generalises the read-port count, the forwarding depth and the register width. It also adds three behaviours the current design lacks: a stall-aware read capture, write-through on read-during-write, and a pending-result hazard output.

## Interface
Parameters:
- XLEN, 32, register width in bits.
- NREGS, 32, architectural register count; must be a power of two; register 0 is hardwired to zero.
- NREAD, 2, number of read ports.
- NFWD, 3, number of forwarding sources; index 0 is the youngest stage.
- TAG_W, 4, instruction tag width.

Ports (IDX_W = log2(NREGS)); one clock, reset synchronous and active-high:
- i_clock  in  1  clock; all state changes on the rising edge.
- i_reset  in  1  synchronous, active-high reset.
- i_stall  in  1  holds the captured read indices and read data.
- i_read_idx  in  NREAD*IDX_W  register indices from fetch; port p occupies bits [p*IDX_W +: IDX_W].
- i_fwd_valid  in  NFWD  source s carries an in-flight destination.
- i_fwd_pending  in  NFWD  source s result is not yet available (load in flight).
- i_fwd_idx  in  NFWD*IDX_W  destination index of source s.
- i_fwd_data  in  NFWD*XLEN  result of source s.
- i_write_tag  in  TAG_W  tag of the retiring instruction.
- i_write_idx  in  IDX_W  destination register of the retiring instruction.
- i_write_data  in  XLEN  write data.
- o_operand  out  NREAD*XLEN  forwarded operand per read port.
- o_hazard  out  1  at least one port depends on a pending source.
- o_retire_count  out  32  count of retired instructions.

## Operation
- Write (tag-change semantics): a write is accepted when i_write_tag differs from the stored last_tag.
  - On acceptance: last_tag is set to i_write_tag and o_retire_count increments.
  - The file entry is written only when i_write_idx is not 0.
  - While the tag is unchanged, nothing is written and the count does not change.
- Read capture, when i_stall is 0:
  - cap_idx[p] is set to i_read_idx[p].
  - cap_data[p] is set to file[i_read_idx[p]].
  - Write-through: if a write is accepted in the same cycle to the same non-zero index, cap_data[p] takes i_write_data.
- Read capture, when i_stall is 1: cap_idx and cap_data hold. An accepted write to a held cap_idx also updates cap_data (write-through while stalled).
- Operand selection per port, combinational, in priority order:
  - If cap_idx is 0, the operand is 0.
  - Otherwise, the lowest s with i_fwd_valid[s] set and i_fwd_idx[s] equal to cap_idx supplies i_fwd_data[s].
  - Otherwise, the operand is cap_data.
- Hazard rule:
  - o_hazard is 1 when, for any port, the winning source has i_fwd_pending set.
  - An older pending source hidden behind a younger non-pending match does not raise a hazard.
  - Index 0 never raises a hazard.
- o_retire_count wraps from 2^32-1 to 0.

## Timing
- Reset values: file entries all 0, last_tag 0, cap_idx 0, cap_data 0, o_retire_count 0, o_operand 0, o_hazard 0.
- Because last_tag resets to 0, the first retiring tag after reset must be non-zero.
- Read latency is 1 cycle from i_read_idx to cap_data. o_operand and o_hazard are combinational from the captured state plus the i_fwd_* inputs, with no further cycle of latency.
- A write accepted at edge N is visible through the file to a capture at edge N+1. A capture at edge N itself sees it through write-through.
- i_reset is sampled at each rising edge. Reset asserted mid-stall or mid-write overrides everything: no write, no count increment.
- The hazard is not registered. The pipeline stalls on o_hazard, and the block simply holds cap_* while i_stall is 1.

## Structure
- Shared package cpu_operand_pkg holds the IDX_W derivation, the TAG_W default and the REG_ZERO constant.
- Sub-module cpu_forward_mux, one instance per read port: priority select over NFWD sources, producing the operand and a per-port hazard bit. o_hazard is the OR of the per-port bits.
- File, last_tag, cap_* and the retire counter live in the top module.

## Test plan
- Reset, then write tag 1 / idx 5 / data 0xDEADBEEF; read idx 5 next cycle -> operand 0xDEADBEEF and o_retire_count 1.
- Write tag 2 to idx 7 while idx 7 is captured in the same cycle -> operand 0x12345678 (write-through). Repeat tag 2 with different data -> no write, count unchanged.
- Captured idx 3 with source 0 (idx 3, 0xA) and source 2 (idx 3, 0xC) both valid -> operand 0xA. Drop source 0 -> 0xC.
- Source 1 pending for idx 4, port 1 captures idx 4 -> o_hazard 1. Add a non-pending source 0 for idx 4 -> o_hazard 0, operand from source 0.
- Port captures idx 0 while a valid pending source has idx 0 -> operand 0, o_hazard 0. Write to idx 0 -> file unchanged, count +1.
- Hold i_stall with idx 9 captured and change i_read_idx -> operand unchanged. A write to idx 9 while stalled updates the operand. Reset mid-stall -> all outputs 0.
